// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, runs a single-outstanding
// req/ack transaction to instruction memory and hands words to decode.
module fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0]        HALT_OP  = 4'b1111
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [ADDR_W-1:0] instr_pc_next,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted
);

    // state   | meaning
    // IDLE    | out of reset, request not yet issued
    // FETCH   | request outstanding at imem_addr
    // HOLD    | instruction presented to decode, waiting for instr_ready
    // DISCARD | wrong-path request outstanding; its data will be dropped
    // HALTED  | HALT_OP accepted, fetch stopped until reset
    typedef enum logic [2:0] {IDLE, FETCH, HOLD, DISCARD, HALTED} state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] addr_inc;
    logic              is_halt;

    assign addr_inc = imem_addr + ADDR_W'(1);
    assign is_halt  = (instr[DATA_W-1 -: 4] == HALT_OP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            imem_req      <= 1'b0;
            imem_addr     <= '0;
            instr_valid   <= 1'b0;
            instr         <= '0;
            instr_pc      <= '0;
            instr_pc_next <= '0;
            halted        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    imem_req <= 1'b1;
                    state    <= FETCH;
                    if (redirect_valid) begin
                        pc        <= redirect_pc;
                        imem_addr <= redirect_pc;
                    end else begin
                        imem_addr <= pc;
                    end
                end
                FETCH: begin
                    if (imem_ack) begin
                        if (redirect_valid) begin
                            // ack closes the old transaction; req stays up for the new target
                            pc        <= redirect_pc;
                            imem_addr <= redirect_pc;
                        end else begin
                            instr         <= imem_rdata;
                            instr_pc      <= imem_addr;
                            instr_pc_next <= addr_inc;
                            instr_valid   <= 1'b1;
                            pc            <= addr_inc;
                            imem_req      <= 1'b0;
                            state         <= HOLD;
                        end
                    end else if (redirect_valid) begin
                        pc    <= redirect_pc;
                        state <= DISCARD;
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        instr_valid <= 1'b0;
                        pc          <= redirect_pc;
                        imem_req    <= 1'b1;
                        imem_addr   <= redirect_pc;
                        state       <= FETCH;
                    end else if (instr_ready) begin
                        instr_valid <= 1'b0;
                        if (is_halt) begin
                            halted <= 1'b1;
                            state  <= HALTED;
                        end else begin
                            imem_req  <= 1'b1;
                            imem_addr <= pc;
                            state     <= FETCH;
                        end
                    end
                end
                DISCARD: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                    end
                    if (imem_ack) begin
                        imem_addr <= redirect_valid ? redirect_pc : pc;
                        state     <= FETCH;
                    end
                end
                HALTED: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written corner sequences
// and a randomized run scored against an architectural PC/stream model.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic [15:0] instr_pc_next;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halted;

    fetch_unit #(
        .ADDR_W  (16),
        .DATA_W  (16),
        .RESET_PC(16'h0000),
        .HALT_OP (4'b1111)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_pc_next (instr_pc_next),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halted        (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %04h expected %04h", name, act, exp);
        end
    endtask

    // instruction memory contents: a fixed pattern (opcode < 8) plus overrides
    logic [15:0] ovr [logic [15:0]];

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        if (ovr.exists(a)) return ovr[a];
        return {1'b0, a[14:0] ^ 15'h2A55};
    endfunction

    // memory responder state
    bit          pending   = 0;
    int          cnt       = 0;
    int          base_lat  = 0;
    bit          rand_lat  = 0;
    logic [16:0] slow_addr = 17'h10000;
    bit          force_ack = 0;
    logic [15:0] force_data;

    // architectural model: next PC expected to be delivered, halt state
    logic [15:0] m_pc   = 16'h0000;
    bit          m_halt = 0;
    int          n_deliv = 0;

    logic        p_valid, p_rdy, p_rv, p_req, p_ack, p_rst;
    logic [15:0] p_instr, p_pc, p_addr;

    task automatic sb_check();
        if (p_rst) begin
            chk("rst_req",    16'(imem_req), 16'h0);
            chk("rst_addr",   imem_addr, 16'h0000);
            chk("rst_valid",  16'(instr_valid), 16'h0);
            chk("rst_instr",  instr, 16'h0000);
            chk("rst_pc",     instr_pc, 16'h0000);
            chk("rst_pcnext", instr_pc_next, 16'h0000);
            chk("rst_halted", 16'(halted), 16'h0);
        end else begin
            chk("sb_halted", 16'(halted), 16'(m_halt));
            if (m_halt) begin
                chk("sb_halt_req",   16'(imem_req), 16'h0);
                chk("sb_halt_valid", 16'(instr_valid), 16'h0);
            end
            if (instr_valid && !p_valid) begin
                n_deliv++;
                chk("sb_deliv_pc",     instr_pc, m_pc);
                chk("sb_deliv_instr",  instr, mem_fn(m_pc));
                chk("sb_deliv_pcnext", instr_pc_next, m_pc + 16'h0001);
            end
            if (p_valid && !p_rdy && !p_rv) begin
                chk("sb_valid_hold", 16'(instr_valid), 16'h1);
                chk("sb_instr_hold", instr, p_instr);
                chk("sb_pc_hold",    instr_pc, p_pc);
            end
            if (p_req && !p_ack) begin
                chk("sb_req_hold",  16'(imem_req), 16'h1);
                chk("sb_addr_hold", imem_addr, p_addr);
            end
        end
    endtask

    task automatic model_update();
        p_valid = instr_valid; p_instr = instr; p_pc = instr_pc;
        p_req = imem_req; p_addr = imem_addr; p_ack = imem_ack;
        p_rdy = instr_ready; p_rv = redirect_valid; p_rst = rst;
        if (rst) begin
            m_pc   = 16'h0000;
            m_halt = 0;
        end else if (!m_halt) begin
            if (redirect_valid) begin
                m_pc = redirect_pc;
            end else if (instr_valid && instr_ready) begin
                if (mem_fn(m_pc) >> 12 == 16'h000F) m_halt = 1;
                m_pc = m_pc + 16'h0001;
            end
        end
    endtask

    // one clock: check outputs, drive memory and handshake inputs, advance
    task automatic cycle(input logic rdy, input logic rv, input logic [15:0] rpc);
        sb_check();
        imem_ack   = 1'b0;
        imem_rdata = 16'($urandom);
        if (!imem_req) begin
            pending = 0;
        end else begin
            if (!pending) begin
                pending = 1;
                if ({1'b0, imem_addr} == slow_addr) cnt = 3;
                else if (rand_lat) cnt = int'($urandom_range(0, 3));
                else cnt = base_lat;
            end
            if (cnt == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_fn(imem_addr);
                pending    = 0;
            end else begin
                cnt--;
            end
        end
        if (force_ack) begin
            imem_ack   = 1'b1;
            imem_rdata = force_data;
            force_ack  = 0;
        end
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle(1'b0, 1'b0, 16'h0);
        cycle(1'b0, 1'b0, 16'h0);
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n;
        n = 0;
        while (!instr_valid && n < budget) begin
            cycle(1'b0, 1'b0, 16'h0);
            n++;
        end
        chk(name, 16'(instr_valid), 16'h1);
    endtask

    typedef struct {
        logic        rdy;
        logic        exp_req;
        logic [15:0] exp_addr;
        logic        exp_valid;
        logic [15:0] exp_pc;
    } vec_t;

    function automatic vec_t mk(logic rdy, logic rq, logic [15:0] a, logic v, logic [15:0] pc);
        vec_t t;
        t.rdy = rdy; t.exp_req = rq; t.exp_addr = a; t.exp_valid = v; t.exp_pc = pc;
        return t;
    endfunction

    initial begin
        vec_t tbl[14];
        int   n;
        bit   found;

        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 16'h0;
        instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0;
        force_data = 16'h0;
        p_valid = 0; p_rdy = 0; p_rv = 0; p_req = 0; p_ack = 0; p_rst = 1;
        p_instr = 16'h0; p_pc = 16'h0; p_addr = 16'h0;
        ovr[16'h0000] = 16'h0123;
        ovr[16'hFFFF] = 16'h8001;

        // zero-wait sequential fetch with a 5-cycle backpressure window on addr 0
        tbl[0]  = mk(1, 0, 16'h0000, 0, 16'h0000);
        tbl[1]  = mk(1, 1, 16'h0000, 0, 16'h0000);
        tbl[2]  = mk(0, 0, 16'h0000, 1, 16'h0000);
        tbl[3]  = mk(0, 0, 16'h0000, 1, 16'h0000);
        tbl[4]  = mk(0, 0, 16'h0000, 1, 16'h0000);
        tbl[5]  = mk(0, 0, 16'h0000, 1, 16'h0000);
        tbl[6]  = mk(0, 0, 16'h0000, 1, 16'h0000);
        tbl[7]  = mk(1, 0, 16'h0000, 1, 16'h0000);
        tbl[8]  = mk(1, 1, 16'h0001, 0, 16'h0000);
        tbl[9]  = mk(1, 0, 16'h0000, 1, 16'h0001);
        tbl[10] = mk(1, 1, 16'h0002, 0, 16'h0000);
        tbl[11] = mk(1, 0, 16'h0000, 1, 16'h0002);
        tbl[12] = mk(1, 1, 16'h0003, 0, 16'h0000);
        tbl[13] = mk(1, 0, 16'h0000, 1, 16'h0003);

        @(negedge clk);
        do_reset();
        for (int i = 0; i < 14; i++) begin
            chk($sformatf("tbl%0d_req", i), 16'(imem_req), 16'(tbl[i].exp_req));
            if (tbl[i].exp_req) chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].exp_addr);
            chk($sformatf("tbl%0d_valid", i), 16'(instr_valid), 16'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) begin
                chk($sformatf("tbl%0d_pc", i), instr_pc, tbl[i].exp_pc);
                chk($sformatf("tbl%0d_instr", i), instr, mem_fn(tbl[i].exp_pc));
                chk($sformatf("tbl%0d_pcnext", i), instr_pc_next, tbl[i].exp_pc + 16'h0001);
            end
            cycle(tbl[i].rdy, 1'b0, 16'h0);
        end

        // redirect while the addr-3 request is outstanding (ack 3 cycles later)
        do_reset();
        slow_addr = 17'h00003;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (imem_req && imem_addr == 16'h0003) found = 1;
            else cycle(1'b1, 1'b0, 16'h0);
        end
        chk("redir_reach", 16'(found), 16'h1);
        cycle(1'b1, 1'b1, 16'h0040);
        n = 0;
        while (imem_req && imem_addr == 16'h0003 && n < 10) begin
            chk("redir_novalid", 16'(instr_valid), 16'h0);
            cycle(1'b1, 1'b0, 16'h0);
            n++;
        end
        chk("redir_discard_len", 16'(n), 16'h3);
        chk("redir_req", 16'(imem_req), 16'h1);
        chk("redir_addr", imem_addr, 16'h0040);
        wait_valid("redir_wait", 10);
        chk("redir_pc", instr_pc, 16'h0040);
        slow_addr = 17'h10000;

        // wrap: squash the held instruction with a redirect to FFFF
        cycle(1'b1, 1'b1, 16'hFFFF);
        chk("wrap_squash", 16'(instr_valid), 16'h0);
        chk("wrap_addr", imem_addr, 16'hFFFF);
        wait_valid("wrap_wait", 10);
        chk("wrap_pc", instr_pc, 16'hFFFF);
        chk("wrap_instr", instr, 16'h8001);
        chk("wrap_pcnext", instr_pc_next, 16'h0000);
        cycle(1'b1, 1'b0, 16'h0);
        chk("wrap_next_req", 16'(imem_req), 16'h1);
        chk("wrap_next_addr", imem_addr, 16'h0000);

        // reset mid-FETCH with a stray late ack in the following cycle
        base_lat = 3;
        rst = 1'b1;
        cycle(1'b0, 1'b0, 16'h0);
        rst = 1'b0;
        chk("rstm_req", 16'(imem_req), 16'h0);
        chk("rstm_valid", 16'(instr_valid), 16'h0);
        force_ack  = 1;
        force_data = 16'hF0F0;
        cycle(1'b0, 1'b0, 16'h0);
        base_lat = 0;
        chk("rstm_req2", 16'(imem_req), 16'h1);
        chk("rstm_addr2", imem_addr, 16'h0000);
        wait_valid("rstm_wait", 10);
        chk("rstm_pc", instr_pc, 16'h0000);
        chk("rstm_instr", instr, 16'h0123);

        // randomized traffic against the model
        rand_lat = 1;
        n = n_deliv;
        for (int i = 0; i < 2000; i++) begin
            logic [15:0] rpc;
            rpc = ($urandom_range(0, 3) == 0) ? (16'hFFFD + 16'($urandom_range(0, 2))) : 16'($urandom);
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 11) == 0, rpc);
        end
        chk("rand_progress", 16'(n_deliv - n > 100), 16'h1);
        rand_lat = 0;

        // halt on F000 at 0x0010; redirect ignored; reset recovers
        ovr[16'h0010] = 16'hF000;
        do_reset();
        wait_valid("halt_wait0", 10);
        cycle(1'b1, 1'b1, 16'h0010);
        wait_valid("halt_wait1", 10);
        chk("halt_instr", instr, 16'hF000);
        chk("halt_pc", instr_pc, 16'h0010);
        cycle(1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 5; i++) begin
            chk("halt_flag", 16'(halted), 16'h1);
            chk("halt_req", 16'(imem_req), 16'h0);
            chk("halt_valid", 16'(instr_valid), 16'h0);
            cycle(1'b1, i == 1, 16'h0020);
        end
        do_reset();
        chk("halt_rst_flag", 16'(halted), 16'h0);
        cycle(1'b0, 1'b0, 16'h0);
        chk("halt_rst_req", 16'(imem_req), 16'h1);
        chk("halt_rst_addr", imem_addr, 16'h0000);
        cycle(1'b0, 1'b0, 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
